mc_cpu_core: RTL and testbench

- Parametrised multi-cycle CPU core. One unit holds the control FSM, register file, ALU, PC/IR and the datapath latches.
- Next-generation core of the lab CPU line. Data width, register count, address width and reset PC are all configurable.
- Adds a unified memory port with a ready handshake (variable memory latency), plus halt/illegal detection and a retired-instruction counter.
- Sits between the board top level and the single shared instruction/data memory.

---
 rtl/mc_cpu_core.sv | 225 ++++++++++++++++++++++
 tb/tb_mc_cpu_core.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mc_cpu_core.sv
// Multi-cycle MIPS-subset CPU core: IF/ID/EX/MEM/WB control FSM, register file,
// ALU and PC/IR in one unit, talking to one shared memory over a req/ready port.
// The read-data port is at least 32 bits wide so a full instruction word can be
// fetched even when DATA_W is narrower than an instruction.
module mc_cpu_core #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int NREG   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    localparam int RD_W = (DATA_W < 32) ? 32 : DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [RD_W-1:0]   mem_rdata,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] pc,
    output logic [2:0]        state,
    output logic              halted,
    output logic              illegal,
    output logic              dbg_wr_en,
    output logic [4:0]        dbg_wr_addr,
    output logic [DATA_W-1:0] dbg_wr_data,
    output logic [31:0]       retired
);
    localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_HALT = 6'h3F;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_ir;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_alu;
    logic [DATA_W-1:0] r_mdr;
    logic [ADDR_W-1:0] r_ea;
    logic              r_illegal;
    logic [31:0]       r_retired;
    logic [DATA_W-1:0] r_regs [NREG];

    logic [5:0]        w_op;
    logic [5:0]        w_funct;
    logic [RW-1:0]     w_rs;
    logic [RW-1:0]     w_rt;
    logic [RW-1:0]     w_rd;
    logic [RW-1:0]     w_dest;
    logic [DATA_W-1:0] w_imm;
    logic [DATA_W-1:0] w_sum;
    logic [DATA_W-1:0] w_wb_data;
    logic              w_unused_shamt;

    // R-type ALU; undefined functs never reach EX, so default is a safe zero.
    function automatic logic [DATA_W-1:0] alu_op(input logic [5:0] funct,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] res;
        case (funct)
            F_ADD:   res = a + b;
            F_SUB:   res = a - b;
            F_AND:   res = a & b;
            F_OR:    res = a | b;
            F_SLT:   res = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            default: res = {DATA_W{1'b0}};
        endcase
        return res;
    endfunction

    // True when the funct field names a supported R-type operation.
    function automatic logic funct_ok(input logic [5:0] funct);
        logic ok;
        case (funct)
            F_ADD, F_SUB, F_AND, F_OR, F_SLT: ok = 1'b1;
            default:                          ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign w_op           = r_ir[31:26];
    assign w_funct        = r_ir[5:0];
    assign w_rs           = r_ir[21 +: RW];
    assign w_rt           = r_ir[16 +: RW];
    assign w_rd           = r_ir[11 +: RW];
    assign w_dest         = (w_op == OP_R) ? w_rd : w_rt;
    assign w_imm          = DATA_W'($signed(r_ir[15:0]));
    assign w_sum          = r_a + w_imm;
    assign w_wb_data      = (w_op == OP_LW) ? r_mdr : r_alu;
    assign w_unused_shamt = ^r_ir[10:6];

    // Memory request is a decode of the state register; gating with rst_n makes it drop asynchronously.
    assign mem_req     = rst_n & ((r_state == S_IF) || (r_state == S_MEM));
    assign mem_we      = mem_req & (r_state == S_MEM) & (w_op == OP_SW);
    assign mem_addr    = (r_state == S_MEM) ? r_ea : r_pc;
    assign mem_wdata   = r_b;
    assign pc          = r_pc;
    assign state       = r_state;
    assign halted      = (r_state == S_HALT);
    assign illegal     = r_illegal;
    assign dbg_wr_en   = (r_state == S_WB) && (w_dest != {RW{1'b0}});
    assign dbg_wr_addr = 5'(w_dest);
    assign dbg_wr_data = w_wb_data;
    assign retired     = r_retired;

    // Control FSM with PC/IR, operand latches, register file and retire counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IF;
            r_pc      <= RESET_PC;
            r_ir      <= 32'd0;
            r_a       <= '0;
            r_b       <= '0;
            r_alu     <= '0;
            r_mdr     <= '0;
            r_ea      <= '0;
            r_illegal <= 1'b0;
            r_retired <= 32'd0;
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IF: begin
                    if (mem_ready) begin
                        r_ir    <= mem_rdata[31:0];
                        r_pc    <= r_pc + ADDR_W'(1);
                        r_state <= S_ID;
                    end
                end
                S_ID: begin
                    r_a <= r_regs[w_rs];
                    r_b <= r_regs[w_rt];
                    case (w_op)
                        OP_J: begin
                            r_pc      <= r_ir[ADDR_W-1:0];
                            r_retired <= r_retired + 32'd1;
                            r_state   <= S_IF;
                        end
                        OP_HALT: r_state <= S_HALT;
                        OP_R: begin
                            if (funct_ok(w_funct)) begin
                                r_state <= S_EX;
                            end else begin
                                r_illegal <= 1'b1;
                                r_state   <= S_HALT;
                            end
                        end
                        OP_ADDI, OP_LW, OP_SW, OP_BEQ: r_state <= S_EX;
                        default: begin
                            r_illegal <= 1'b1;
                            r_state   <= S_HALT;
                        end
                    endcase
                end
                S_EX: begin
                    case (w_op)
                        OP_R: begin
                            r_alu   <= alu_op(w_funct, r_a, r_b);
                            r_state <= S_WB;
                        end
                        OP_ADDI: begin
                            r_alu   <= w_sum;
                            r_state <= S_WB;
                        end
                        OP_LW, OP_SW: begin
                            r_ea    <= w_sum[ADDR_W-1:0];
                            r_state <= S_MEM;
                        end
                        OP_BEQ: begin
                            if (r_a == r_b) begin
                                r_pc <= r_pc + w_imm[ADDR_W-1:0];
                            end
                            r_retired <= r_retired + 32'd1;
                            r_state   <= S_IF;
                        end
                        default: r_state <= S_HALT;
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (w_op == OP_SW) begin
                            r_retired <= r_retired + 32'd1;
                            r_state   <= S_IF;
                        end else begin
                            r_mdr   <= mem_rdata[DATA_W-1:0];
                            r_state <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    if (w_dest != {RW{1'b0}}) begin
                        r_regs[w_dest] <= w_wb_data;
                    end
                    r_retired <= r_retired + 32'd1;
                    r_state   <= S_IF;
                end
                S_HALT: r_state <= S_HALT;
                default: r_state <= S_HALT;
            endcase
        end
    end
endmodule

// File: tb/tb_mc_cpu_core.sv
// Directed bench for mc_cpu_core: default 32-bit core on a memory model with
// programmable wait states, plus a 16-bit/4-bit-address core on zero-wait memory.
module tb_mc_cpu_core;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_req, mem_we, mem_ready;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [7:0]  pc;
    logic [2:0]  state;
    logic        halted, illegal, dbg_wr_en;
    logic [4:0]  dbg_wr_addr;
    logic [31:0] dbg_wr_data, retired;

    logic        m2_req, m2_we, m2_ready, m2_halted, m2_illegal, m2_dbg_en;
    logic [3:0]  m2_addr, m2_pc;
    logic [15:0] m2_wdata, m2_dbg_data;
    logic [31:0] m2_rdata, m2_retired;
    logic [2:0]  m2_state;
    logic [4:0]  m2_dbg_addr;

    logic [31:0] mem  [256];
    logic [31:0] mem2 [16];
    int          wait_cfg;
    int          r_wait;
    logic        st_valid;
    logic [7:0]  st_addr;
    logic [31:0] st_data;
    int          checks;
    int          errors;
    int          cyc;

    always #5 clk = ~clk;

    mc_cpu_core dut (
        .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .pc(pc), .state(state), .halted(halted),
        .illegal(illegal), .dbg_wr_en(dbg_wr_en), .dbg_wr_addr(dbg_wr_addr),
        .dbg_wr_data(dbg_wr_data), .retired(retired)
    );

    mc_cpu_core #(.DATA_W(16), .ADDR_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .mem_req(m2_req), .mem_we(m2_we),
        .mem_addr(m2_addr), .mem_wdata(m2_wdata), .mem_rdata(m2_rdata),
        .mem_ready(m2_ready), .pc(m2_pc), .state(m2_state), .halted(m2_halted),
        .illegal(m2_illegal), .dbg_wr_en(m2_dbg_en), .dbg_wr_addr(m2_dbg_addr),
        .dbg_wr_data(m2_dbg_data), .retired(m2_retired)
    );

    // Memory model: ready after wait_cfg stalled cycles; the last store is read back through a bypass.
    always_comb begin
        mem_ready = mem_req && (r_wait >= wait_cfg);
        mem_rdata = (st_valid && (st_addr == mem_addr)) ? st_data : mem[mem_addr];
        m2_ready  = 1'b1;
        m2_rdata  = mem2[m2_addr];
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            r_wait   <= 0;
            st_valid <= 1'b0;
        end else begin
            if (mem_req && !mem_ready) r_wait <= r_wait + 1;
            else                       r_wait <= 0;
            if (mem_req && mem_we && mem_ready) begin
                st_valid <= 1'b1;
                st_addr  <= mem_addr;
                st_data  <= mem_wdata;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic to_cycle(input int c);
        while (cyc < c) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic start_prog();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; wait_cfg = 0; rst_n = 1'b0;
        clear_mem();
        for (int i = 0; i < 16; i++) mem2[i] = 32'd0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_pc", 64'(pc), 64'd0);
        chk("rst_req", 64'(mem_req), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_retired", 64'(retired), 64'd0);
        chk("rst_dbg_en", 64'(dbg_wr_en), 64'd0);

        // Program 1: addi/addi/add/halt, zero wait; 16-bit core runs alongside.
        mem[0] = 32'h2001_0005; mem[1] = 32'h2002_FFFD;
        mem[2] = 32'h0022_1820; mem[3] = 32'hFC00_0000;
        mem2[0] = 32'h2001_FFFF; mem2[1] = 32'h0800_000F; mem2[15] = 32'h2002_0001;
        start_prog();
        to_cycle(4);
        chk("p1_wr1_en", 64'(dbg_wr_en), 64'd1);
        chk("p1_wr1", {32'(dbg_wr_addr), dbg_wr_data}, {32'd1, 32'd5});
        chk("w16_wr", {31'd0, m2_dbg_en, 16'(m2_dbg_addr), m2_dbg_data}, {31'd0, 1'b1, 16'd1, 16'hFFFF});
        to_cycle(7);
        chk("w16_j_pc", {32'(m2_state), 32'(m2_pc)}, {32'd0, 32'd15});
        to_cycle(8);
        chk("p1_wr2", {32'(dbg_wr_addr), dbg_wr_data}, {32'd2, 32'hFFFF_FFFD});
        chk("w16_pc_wrap", 64'(m2_pc), 64'd0);
        to_cycle(12);
        chk("p1_add", {31'd0, dbg_wr_en, 32'(dbg_wr_addr), dbg_wr_data}, {31'd0, 1'b1, 32'd3, 32'd2});
        to_cycle(14);
        chk("p1_not_yet_halted", 64'(halted), 64'd0);
        to_cycle(15);
        chk("p1_halted", {32'(halted), 32'(state)}, {32'd1, 32'd5});
        chk("p1_retired", 64'(retired), 64'd3);
        chk("p1_illegal", 64'(illegal), 64'd0);
        chk("p1_halt_req", 64'(mem_req), 64'd0);
        to_cycle(20);
        chk("p1_frozen", {32'(pc), retired}, {32'd4, 32'd3});

        // Program 2: store then load with three wait cycles per request.
        clear_mem();
        mem[0] = 32'h2001_0005; mem[1] = 32'hAC01_0004;
        mem[2] = 32'h8C04_0004; mem[3] = 32'hFC00_0000;
        wait_cfg = 3;
        start_prog();
        to_cycle(4);
        chk("p2_if_wait_state", 64'(state), 64'd0);
        for (int c = 14; c <= 17; c++) begin
            to_cycle(c);
            chk("p2_sw_hold", {29'd0, mem_req, mem_we, 1'b0, 16'(mem_addr), mem_wdata[15:0]},
                {29'd0, 1'b1, 1'b1, 1'b0, 16'd4, 16'd5});
        end
        to_cycle(18);
        chk("p2_sw_retire", {32'(state), retired}, {32'd0, 32'd2});
        to_cycle(27);
        chk("p2_lw_mem", {32'(state), 31'd0, dbg_wr_en}, {32'd3, 32'd0});
        to_cycle(28);
        chk("p2_lw_wb", {31'd0, dbg_wr_en, 32'(dbg_wr_addr), dbg_wr_data}, {31'd0, 1'b1, 32'd4, 32'd5});
        to_cycle(29);
        chk("p2_retired", 64'(retired), 64'd3);
        to_cycle(34);
        chk("p2_halted", 64'(halted), 64'd1);

        // Program 3: beq loop, r0 write discard, illegal opcode.
        clear_mem();
        mem[0] = 32'h2001_0005; mem[1] = 32'h1021_FFFF; mem[2] = 32'h2000_0007;
        mem[3] = 32'h0000_2820; mem[4] = 32'hF800_0000;
        wait_cfg = 0;
        start_prog();
        to_cycle(8);
        chk("p3_loop1", {32'(pc), retired}, {32'd1, 32'd2});
        to_cycle(11);
        chk("p3_loop2", {32'(pc), retired}, {32'd1, 32'd3});
        mem[1] = 32'h1020_FFFF;
        to_cycle(14);
        chk("p3_beq_nt", {32'(pc), retired}, {32'd2, 32'd4});
        to_cycle(17);
        chk("p3_r0_wb", {32'(state), 31'd0, dbg_wr_en}, {32'd4, 32'd0});
        to_cycle(21);
        chk("p3_add_r5", {31'd0, dbg_wr_en, 32'(dbg_wr_addr), dbg_wr_data}, {31'd0, 1'b1, 32'd5, 32'd0});
        to_cycle(24);
        chk("p3_illegal", {32'(illegal), 32'(halted)}, {32'd1, 32'd1});
        chk("p3_ill_retired", 64'(retired), 64'd6);
        to_cycle(28);
        chk("p3_frozen", {31'd0, mem_req, 24'd0, pc, retired}, {32'd0, 32'd5, 32'd6});

        // Program 4: asynchronous reset in the middle of a stalled store.
        clear_mem();
        mem[0] = 32'h2001_0009; mem[1] = 32'hAC01_0008;
        wait_cfg = 0;
        start_prog();
        to_cycle(7);
        wait_cfg = 50;
        to_cycle(10);
        chk("p4_mem_wait", {29'd0, state, 22'd0, mem_req, mem_we, mem_addr}, {29'd3, 24'd3, 8'd8});
        chk("p4_pre_rst", {32'(pc), retired}, {32'd2, 32'd1});
        #2 rst_n = 1'b0;
        #1;
        chk("p4_req_drop", 64'(mem_req), 64'd0);
        chk("p4_after_rst", {24'd0, pc, 29'd0, state}, {32'd0, 32'd0});
        chk("p4_retired_clr", 64'(retired), 64'd0);
        wait_cfg = 0;
        @(negedge clk);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
